dmem_access_unit: RTL and testbench
===================================

// Module: dmem_access_unit
// PURPOSE
//  Multi-cycle data-memory access stage downstream of the control decoder. It consumes
//  en_dmem/load_store/funct3_dmem plus the ALU address and rs2 data, and runs a req/ack word bus
//  with byte-lane enables. It returns the aligned, sign/zero-extended load result for writeback
//  and holds stall high to freeze PC/regfile until the access completes.
// PARAMETERS
//  TIMEOUT_CYC  64  cycles in REQ without bus_ack before abort (>=1)
// PORTS
//  clk           in   1   single clock, rising edge
//  rst_n         in   1   asynchronous active-low reset
//  en_dmem       in   1   access requested by current instruction (level, held while stall=1)
//  load_store    in   1   0=load, 1=store
//  funct3_dmem   in   3   000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
//  addr          in   32  byte address from ALU
//  wdata         in   32  store data (rs2)
//  rdata         out  32  extended load result, registered
//  stall         out  1   hold PC/regfile this cycle
//  done          out  1   1-cycle pulse: access finished (ok, misaligned or timeout)
//  misalign      out  1   1-cycle pulse with done: misaligned/illegal access, no bus cycle
//  timeout       out  1   1-cycle pulse with done: bus_ack never arrived
//  bus_req       out  1   bus request
//  bus_we        out  1   1=write
//  bus_addr      out  32  {addr[31:2],2'b00}
//  bus_be        out  4   byte-lane enables
//  bus_wdata     out  32  lane-replicated store data
//  bus_ack       in   1   bus completion (1 cycle)
//  bus_rdata     in   32  read word, valid with bus_ack
// BEHAVIOUR
//  Reset: state IDLE, all registered outputs 0, counter 0; stall forced 0 while rst_n=0.
//   Reset asserted in REQ drops bus_req immediately; the access is abandoned.
//  FSM IDLE -> REQ -> DONE -> IDLE.
//   IDLE: en_dmem=1 -> latch addr/wdata/size/dir; legal -> REQ, illegal -> DONE with misalign.
//         stall = en_dmem (combinational). en_dmem=0 -> stay.
//   REQ:  bus_req=1; bus_we/addr/be/wdata stable until ack; stall=1; counter++ each cycle.
//         bus_ack=1 -> capture extended load data into rdata (stores leave rdata unchanged) -> DONE.
//         counter==TIMEOUT_CYC-1 w/o ack -> rdata=0, timeout -> DONE.
//   DONE: stall=0, done=1 for one cycle; en_dmem is not sampled here (no re-issue) -> IDLE.
//  Latency: accept cycle 0, bus_req from cycle 1, ack in cycle k>=1 -> done in cycle k+1.
//   Min 3 cycles with stall=1 for cycles 0..k.
//  Illegal: H at addr[0]=1; W at addr[1:0]!=0; funct3 011/110/111; store with 100/101.
//   -> no bus_req, rdata=0.
//  Lanes: B be=4'b0001<<addr[1:0], wdata {4{b}}; H be=4'b0011<<{addr[1],1'b0}, {2{h}};
//   W be=4'b1111.
//  Loads: select lane by addr[1:0]; B/H sign-extend, BU/HU zero-extend, W pass-through.
//   Loads use the same be pattern.
//  bus_ack outside REQ ignored. rdata holds until next completed load/abort.
//  done/misalign/timeout never overlap a following accept.
// TESTING
//  SW addr=0x104 wdata=0xDEADBEEF, ack 2 cycles after req -> be=1111, bus_addr=0x104,
//   stall 4 cycles, done pulse.
//  LB addr=0x203, bus_rdata=0x80FF_1234 -> be=1000, rdata=0xFFFFFF80.
//   LBU same -> rdata=0x00000080.
//  SH addr=0x12 wdata=0x0000ABCD -> be=1100, bus_wdata=0xABCDABCD.
//   LH addr=0x13 -> misalign pulse, no bus_req, rdata=0.
//  No ack for TIMEOUT_CYC=64 -> bus_req drops after 64 cycles, timeout+done pulse, rdata=0.
//  Back-to-back LW then SW with en_dmem held high -> exactly two bus transactions, IDLE gap
//   between them.
//  rst_n low mid-REQ -> bus_req/stall 0 immediately; after release en_dmem=1 starts a fresh access.

Source files
------------

// File: rtl/dmem_access_unit_if.sv
// ---------------------------------------------------------------------------
// dmem_access_unit_if
//   Word-wide request/acknowledge data-memory bus with byte-lane enables.
//   The access unit is the master. A memory model or bus fabric is the slave.
//
//   bus_req    master -> slave  request held until bus_ack
//   bus_we     master -> slave  1 = write, 0 = read
//   bus_addr   master -> slave  word-aligned byte address
//   bus_be     master -> slave  byte-lane enables, bit n = byte lane n
//   bus_wdata  master -> slave  lane-replicated write data
//   bus_ack    slave -> master  one-cycle completion strobe
//   bus_rdata  slave -> master  read word, valid together with bus_ack
// ---------------------------------------------------------------------------
interface dmem_access_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack;
  logic [31:0] bus_rdata;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_ack, bus_rdata
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_ack, bus_rdata
  );
endinterface

// File: rtl/dmem_access_unit.sv
// ---------------------------------------------------------------------------
// dmem_access_unit
//   Multi-cycle data-memory access stage. It accepts a load or store from the
//   control decoder, checks alignment and legality, and runs one request on
//   the req/ack word bus. It returns the aligned and sign/zero-extended load
//   result, and it holds stall high until the access completes.
//
//   Parameters
//     TIMEOUT_CYC  cycles spent in REQ without bus_ack before the access is
//                  aborted (must be >= 1)
//
//   Ports
//     clk, rst_n    clock (rising edge), asynchronous active-low reset
//     en_dmem       access requested, held by the pipeline while stall=1
//     load_store    0 = load, 1 = store
//     funct3_dmem   000 B, 001 H, 010 W, 100 BU, 101 HU
//     addr, wdata   byte address from the ALU, store data (rs2)
//     rdata         registered, extended load result
//     stall         freeze PC/regfile this cycle
//     done          one-cycle completion pulse
//     misalign      with done: illegal/misaligned access, no bus cycle issued
//     timeout       with done: bus_ack never arrived
//     bus           master side of the data-memory bus
// ---------------------------------------------------------------------------
module dmem_access_unit #(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en_dmem,
  input  logic                    load_store,
  input  logic [2:0]              funct3_dmem,
  input  logic [31:0]             addr,
  input  logic [31:0]             wdata,
  output logic [31:0]             rdata,
  output logic                    stall,
  output logic                    done,
  output logic                    misalign,
  output logic                    timeout,
  dmem_access_unit_if.master      bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Wide enough to hold TIMEOUT_CYC-1, with a minimum of one bit.
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;

  // Request attributes latched at accept and held stable for the whole bus cycle.
  logic             we_q;
  logic [31:0]      addr_q;
  logic [1:0]       size_q;
  logic             unsigned_q;
  logic [3:0]       be_q;
  logic [31:0]      wdata_q;

  logic             legal_c;
  logic [3:0]       be_c;
  logic [31:0]      wdata_c;
  logic [31:0]      rd_shift;
  logic [31:0]      load_ext;

  // BU/HU exist only as loads. Halfwords need an even address, and words need
  // an address that is a multiple of 4.
  always_comb begin
    legal_c = 1'b0;
    case (funct3_dmem)
      3'b000:  legal_c = 1'b1;
      3'b001:  legal_c = ~addr[0];
      3'b010:  legal_c = (addr[1:0] == 2'b00);
      3'b100:  legal_c = ~load_store;
      3'b101:  legal_c = ~load_store & ~addr[0];
      default: legal_c = 1'b0;
    endcase
  end

  // Byte-lane enables and lane-replicated store data for the incoming request.
  always_comb begin
    be_c    = 4'b1111;
    wdata_c = wdata;
    case (funct3_dmem[1:0])
      2'b00: begin
        be_c    = 4'b0001 << addr[1:0];
        wdata_c = {4{wdata[7:0]}};
      end
      2'b01: begin
        be_c    = 4'b0011 << {addr[1], 1'b0};
        wdata_c = {2{wdata[15:0]}};
      end
      default: begin
        be_c    = 4'b1111;
        wdata_c = wdata;
      end
    endcase
  end

  // Shift the addressed lane down to bit 0, then extend according to size and
  // signedness. Legal halfwords have addr[0]=0, so the shift always lands on a
  // lane boundary.
  always_comb begin
    rd_shift = bus.bus_rdata >> {addr_q[1:0], 3'b000};
    load_ext = bus.bus_rdata;
    case (size_q)
      2'b00: load_ext = unsigned_q ? {24'd0, rd_shift[7:0]}
                                   : {{24{rd_shift[7]}}, rd_shift[7:0]};
      2'b01: load_ext = unsigned_q ? {16'd0, rd_shift[15:0]}
                                   : {{16{rd_shift[15]}}, rd_shift[15:0]};
      default: load_ext = bus.bus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      size_q     <= 2'd0;
      unsigned_q <= 1'b0;
      be_q       <= 4'd0;
      wdata_q    <= 32'd0;
      rdata      <= 32'd0;
      done       <= 1'b0;
      misalign   <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      done     <= 1'b0;
      misalign <= 1'b0;
      timeout  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (en_dmem) begin
            we_q       <= load_store;
            addr_q     <= addr;
            size_q     <= funct3_dmem[1:0];
            unsigned_q <= funct3_dmem[2];
            be_q       <= be_c;
            wdata_q    <= wdata_c;
            cnt        <= '0;
            if (legal_c) begin
              state <= ST_REQ;
            end else begin
              // Rejected without touching the bus. The result register is cleared.
              rdata    <= 32'd0;
              done     <= 1'b1;
              misalign <= 1'b1;
              state    <= ST_DONE;
            end
          end
        end
        ST_REQ: begin
          // An acknowledge in the last allowed cycle still completes normally.
          if (bus.bus_ack) begin
            if (!we_q) begin
              rdata <= load_ext;
            end
            done  <= 1'b1;
            state <= ST_DONE;
          end else if (cnt == CNT_LAST) begin
            rdata   <= 32'd0;
            done    <= 1'b1;
            timeout <= 1'b1;
            state   <= ST_DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          // The pipeline advances during this cycle, so en_dmem still shows the
          // finished instruction and must not be sampled here.
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Stall is decoded from state so that reset releases the pipeline at once,
  // without waiting for a clock edge.
  always_comb begin
    stall = 1'b0;
    if (rst_n) begin
      case (state)
        ST_IDLE: stall = en_dmem;
        ST_REQ:  stall = 1'b1;
        default: stall = 1'b0;
      endcase
    end
  end

  assign bus.bus_req   = (state == ST_REQ);
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = {addr_q[31:2], 2'b00};
  assign bus.bus_be    = be_q;
  assign bus.bus_wdata = wdata_q;

endmodule

// File: tb/tb_dmem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_dmem_access_unit
//   Self-checking bench for dmem_access_unit. A behavioural model computes the
//   expected legality, lanes, store data and extended load result with plain
//   arithmetic. Directed scenarios are followed by randomized accesses.
// ---------------------------------------------------------------------------
module tb_dmem_access_unit;

  localparam int TIMEOUT_CYC = 64;

  logic        clk;
  logic        rst_n;
  logic        en_dmem;
  logic        load_store;
  logic [2:0]  funct3_dmem;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        done;
  logic        misalign;
  logic        timeout;

  dmem_access_unit_if bus_if ();

  dmem_access_unit #(.TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_dmem     (en_dmem),
    .load_store  (load_store),
    .funct3_dmem (funct3_dmem),
    .addr        (addr),
    .wdata       (wdata),
    .rdata       (rdata),
    .stall       (stall),
    .done        (done),
    .misalign    (misalign),
    .timeout     (timeout),
    .bus         (bus_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] ref_rdata = 32'd0;

  typedef struct {
    bit          finished;
    int          stall_cnt;
    int          req_cnt;
    bit          mis;
    bit          tmo;
    bit          stable;
    logic        we;
    logic [31:0] baddr;
    logic [3:0]  be;
    logic [31:0] bwdata;
    logic [31:0] rdata;
  } obs_t;

  // ---------------- reference model ----------------
  function automatic int ref_size(input logic [2:0] f3);
    logic [1:0] s;
    s = f3[1:0];
    if (s == 2'd0) return 1;
    if (s == 2'd1) return 2;
    return 4;
  endfunction

  function automatic bit ref_legal(input logic ls, input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      3'd0:    return 1'b1;
      3'd1:    return (a % 2) == 0;
      3'd2:    return (a % 4) == 0;
      3'd4:    return !ls;
      3'd5:    return !ls && ((a % 2) == 0);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] ref_be(input logic [2:0] f3, input logic [31:0] a);
    int sz;
    int v;
    sz = ref_size(f3);
    v  = ((1 << sz) - 1) << (a % 4);
    return v[3:0];
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] wd);
    int sz;
    sz = ref_size(f3);
    if (sz == 1) return (wd & 32'hFF) * 32'h0101_0101;
    if (sz == 2) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
    int sz;
    logic [31:0] mask;
    logic [31:0] val;
    sz = ref_size(f3);
    if (sz == 4) return rd;
    mask = (32'd1 << (8 * sz)) - 32'd1;
    val  = (rd >> (8 * (a % 4))) & mask;
    if (!f3[2] && val[8*sz-1]) val = val | ~mask;
    return val;
  endfunction

  // Drives one access and records what the DUT did. ack_at is the REQ cycle
  // (1-based) on which bus_ack is returned; 0 means never.
  task automatic do_access(input logic ls, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] rd,
                           input int ack_at, output obs_t o);
    o = '{default: '0};
    o.stable = 1'b1;
    @(posedge clk);
    #1;
    en_dmem     = 1'b1;
    load_store  = ls;
    funct3_dmem = f3;
    addr        = a;
    wdata       = wd;
    bus_if.bus_ack   = 1'b0;
    bus_if.bus_rdata = rd;
    for (int cyc = 0; cyc < 200; cyc++) begin
      @(negedge clk);
      if (stall) o.stall_cnt++;
      bus_if.bus_ack = 1'b0;
      if (bus_if.bus_req) begin
        o.req_cnt++;
        if (o.req_cnt == 1) begin
          o.we     = bus_if.bus_we;
          o.baddr  = bus_if.bus_addr;
          o.be     = bus_if.bus_be;
          o.bwdata = bus_if.bus_wdata;
        end else if (bus_if.bus_we !== o.we || bus_if.bus_addr !== o.baddr ||
                     bus_if.bus_be !== o.be || bus_if.bus_wdata !== o.bwdata) begin
          o.stable = 1'b0;
        end
        if (o.req_cnt == ack_at) bus_if.bus_ack = 1'b1;
      end
      if (done) begin
        o.finished = 1'b1;
        o.mis      = misalign;
        o.tmo      = timeout;
        o.rdata    = rdata;
        en_dmem    = 1'b0;
        break;
      end
    end
    bus_if.bus_ack = 1'b0;
    en_dmem        = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    en_dmem = 1'b1; load_store = 1'b0; funct3_dmem = 3'd2; addr = 32'h100; wdata = 32'd0;
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    n_checks++;
    if (stall !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_stall: got %b expected 0", stall); end
    n_checks++;
    if (bus_if.bus_req !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_bus_req: got %b expected 0", bus_if.bus_req); end
    n_checks++;
    if ({done, misalign, timeout} !== 3'b000) begin
      n_fail++; $display("[TB] FAIL reset_pulses: got %b expected 000", {done, misalign, timeout});
    end
    n_checks++;
    if (rdata !== 32'd0 || bus_if.bus_be !== 4'd0) begin
      n_fail++; $display("[TB] FAIL reset_regs: rdata %h be %b expected 0", rdata, bus_if.bus_be);
    end
    en_dmem = 1'b0;
    bus_if.bus_ack = 1'b0;
    rst_n = 1'b1;
    ref_rdata = 32'd0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_store_word();
    obs_t o;
    do_access(1'b1, 3'd2, 32'h104, 32'hDEAD_BEEF, 32'd0, 3, o);
    n_checks++;
    if (!o.finished || o.mis || o.tmo) begin
      n_fail++; $display("[TB] FAIL sw_done: fin %b mis %b tmo %b expected 1 0 0", o.finished, o.mis, o.tmo);
    end
    n_checks++;
    if (o.be !== 4'b1111 || o.baddr !== 32'h104 || o.we !== 1'b1) begin
      n_fail++; $display("[TB] FAIL sw_bus: be %b addr %h we %b expected 1111 00000104 1", o.be, o.baddr, o.we);
    end
    n_checks++;
    if (o.bwdata !== 32'hDEAD_BEEF) begin n_fail++; $display("[TB] FAIL sw_wdata: got %h expected deadbeef", o.bwdata); end
    n_checks++;
    if (o.stall_cnt != 4) begin n_fail++; $display("[TB] FAIL sw_stall_cycles: got %0d expected 4", o.stall_cnt); end
    n_checks++;
    if (o.rdata !== ref_rdata) begin n_fail++; $display("[TB] FAIL sw_rdata_hold: got %h expected %h", o.rdata, ref_rdata); end
  endtask

  task automatic test_load_byte();
    obs_t o;
    do_access(1'b0, 3'd0, 32'h203, 32'd0, 32'h80FF_1234, 1, o);
    n_checks++;
    if (o.be !== 4'b1000 || o.baddr !== 32'h200) begin
      n_fail++; $display("[TB] FAIL lb_bus: be %b addr %h expected 1000 00000200", o.be, o.baddr);
    end
    n_checks++;
    if (o.rdata !== 32'hFFFF_FF80) begin n_fail++; $display("[TB] FAIL lb_rdata: got %h expected ffffff80", o.rdata); end
    do_access(1'b0, 3'd4, 32'h203, 32'd0, 32'h80FF_1234, 2, o);
    n_checks++;
    if (o.rdata !== 32'h0000_0080) begin n_fail++; $display("[TB] FAIL lbu_rdata: got %h expected 00000080", o.rdata); end
    ref_rdata = 32'h0000_0080;
  endtask

  task automatic test_store_half();
    obs_t o;
    do_access(1'b1, 3'd1, 32'h12, 32'h0000_ABCD, 32'd0, 2, o);
    n_checks++;
    if (o.be !== 4'b1100 || o.bwdata !== 32'hABCD_ABCD) begin
      n_fail++; $display("[TB] FAIL sh_lanes: be %b wdata %h expected 1100 abcdabcd", o.be, o.bwdata);
    end
  endtask

  task automatic test_misalign();
    obs_t o;
    do_access(1'b0, 3'd1, 32'h13, 32'd0, 32'h1234_5678, 1, o);
    n_checks++;
    if (!o.finished || !o.mis || o.tmo) begin
      n_fail++; $display("[TB] FAIL lh_misalign: fin %b mis %b tmo %b expected 1 1 0", o.finished, o.mis, o.tmo);
    end
    n_checks++;
    if (o.req_cnt != 0) begin n_fail++; $display("[TB] FAIL lh_no_req: got %0d req cycles expected 0", o.req_cnt); end
    n_checks++;
    if (o.rdata !== 32'd0) begin n_fail++; $display("[TB] FAIL lh_rdata: got %h expected 0", o.rdata); end
    ref_rdata = 32'd0;
  endtask

  task automatic test_timeout();
    obs_t o;
    do_access(1'b0, 3'd2, 32'h40, 32'd0, 32'h5555_AAAA, 1, o);
    n_checks++;
    if (o.rdata !== 32'h5555_AAAA) begin n_fail++; $display("[TB] FAIL lw_rdata: got %h expected 5555aaaa", o.rdata); end
    do_access(1'b0, 3'd2, 32'h44, 32'd0, 32'h1111_1111, 0, o);
    n_checks++;
    if (!o.finished || !o.tmo || o.mis) begin
      n_fail++; $display("[TB] FAIL timeout_pulse: fin %b tmo %b mis %b expected 1 1 0", o.finished, o.tmo, o.mis);
    end
    n_checks++;
    if (o.req_cnt != TIMEOUT_CYC) begin
      n_fail++; $display("[TB] FAIL timeout_req_cycles: got %0d expected %0d", o.req_cnt, TIMEOUT_CYC);
    end
    n_checks++;
    if (o.rdata !== 32'd0) begin n_fail++; $display("[TB] FAIL timeout_rdata: got %h expected 0", o.rdata); end
    ref_rdata = 32'd0;
  endtask

  task automatic test_back_to_back();
    int txn = 0;
    int gap = 0;
    int gap_obs = -1;
    int dones = 0;
    logic req_prev = 1'b0;
    logic we2 = 1'b0;
    logic [31:0] rd1 = 32'h0BAD_F00D;
    logic [31:0] r1 = 32'd0;
    @(posedge clk);
    #1;
    en_dmem = 1'b1; load_store = 1'b0; funct3_dmem = 3'd2; addr = 32'h300; wdata = 32'd0;
    bus_if.bus_rdata = rd1;
    for (int cyc = 0; cyc < 100; cyc++) begin
      @(negedge clk);
      if (bus_if.bus_req && !req_prev) begin
        txn++;
        if (txn == 2) begin gap_obs = gap; we2 = bus_if.bus_we; end
      end
      if (!bus_if.bus_req && txn == 1) gap++;
      bus_if.bus_ack = bus_if.bus_req;
      req_prev = bus_if.bus_req;
      if (done) begin
        dones++;
        if (dones == 1) begin
          r1 = rdata;
          load_store = 1'b1; addr = 32'h304; wdata = 32'h1357_9BDF;
        end else begin
          break;
        end
      end
    end
    en_dmem = 1'b0;
    bus_if.bus_ack = 1'b0;
    repeat (4) @(negedge clk) if (bus_if.bus_req && !req_prev) txn++;
    n_checks++;
    if (dones != 2 || txn != 2) begin
      n_fail++; $display("[TB] FAIL b2b_count: dones %0d txns %0d expected 2 2", dones, txn);
    end
    n_checks++;
    if (gap_obs != 2) begin n_fail++; $display("[TB] FAIL b2b_idle_gap: got %0d expected 2", gap_obs); end
    n_checks++;
    if (r1 !== rd1 || we2 !== 1'b1) begin
      n_fail++; $display("[TB] FAIL b2b_data: rdata %h we2 %b expected %h 1", r1, we2, rd1);
    end
    ref_rdata = rd1;
  endtask

  task automatic test_reset_mid_req();
    logic [31:0] rd = $urandom;
    bit seen = 1'b0;
    logic [31:0] r = 32'd0;
    @(posedge clk);
    #1;
    en_dmem = 1'b1; load_store = 1'b0; funct3_dmem = 3'd2; addr = 32'h80;
    bus_if.bus_ack = 1'b0; bus_if.bus_rdata = rd;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus_if.bus_req !== 1'b1) begin n_fail++; $display("[TB] FAIL midreq_active: got %b expected 1", bus_if.bus_req); end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus_if.bus_req !== 1'b0 || stall !== 1'b0) begin
      n_fail++; $display("[TB] FAIL midreq_reset_drop: req %b stall %b expected 0 0", bus_if.bus_req, stall);
    end
    @(negedge clk);
    rst_n = 1'b1;
    funct3_dmem = 3'd0; addr = 32'h81;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      bus_if.bus_ack = bus_if.bus_req;
      if (done) begin seen = 1'b1; r = rdata; break; end
    end
    en_dmem = 1'b0;
    bus_if.bus_ack = 1'b0;
    ref_rdata = ref_load(3'd0, 32'h81, rd);
    n_checks++;
    if (!seen || r !== ref_rdata) begin
      n_fail++; $display("[TB] FAIL midreq_fresh_access: done %b rdata %h expected 1 %h", seen, r, ref_rdata);
    end
  endtask

  task automatic test_random();
    obs_t o;
    for (int i = 0; i < 40; i++) begin
      logic        ls  = 1'($urandom);
      logic [2:0]  f3  = 3'($urandom_range(0, 7));
      logic [31:0] a   = $urandom;
      logic [31:0] wd  = $urandom;
      logic [31:0] rd  = $urandom;
      int          dly = $urandom_range(1, 6);
      bit          lg;
      lg = ref_legal(ls, f3, a);
      do_access(ls, f3, a, wd, rd, dly, o);
      if (!lg) ref_rdata = 32'd0;
      else if (!ls) ref_rdata = ref_load(f3, a, rd);
      n_checks++;
      if (!o.finished || o.mis !== !lg || o.tmo) begin
        n_fail++; $display("[TB] FAIL rnd%0d_status: fin %b mis %b tmo %b expected 1 %b 0", i, o.finished, o.mis, o.tmo, !lg);
      end
      n_checks++;
      if (o.req_cnt != (lg ? dly : 0) || o.stall_cnt != (lg ? dly + 1 : 1)) begin
        n_fail++; $display("[TB] FAIL rnd%0d_timing: req %0d stall %0d expected %0d %0d", i, o.req_cnt, o.stall_cnt,
                           lg ? dly : 0, lg ? dly + 1 : 1);
      end
      n_checks++;
      if (o.rdata !== ref_rdata) begin n_fail++; $display("[TB] FAIL rnd%0d_rdata: got %h expected %h", i, o.rdata, ref_rdata); end
      if (lg) begin
        n_checks++;
        if (o.be !== ref_be(f3, a) || o.baddr !== (a & ~32'd3) || o.we !== ls || !o.stable) begin
          n_fail++; $display("[TB] FAIL rnd%0d_bus: be %b addr %h we %b stable %b expected %b %h %b 1", i, o.be, o.baddr,
                             o.we, o.stable, ref_be(f3, a), a & ~32'd3, ls);
        end
        if (ls) begin
          n_checks++;
          if (o.bwdata !== ref_wdata(f3, wd)) begin
            n_fail++; $display("[TB] FAIL rnd%0d_wdata: got %h expected %h", i, o.bwdata, ref_wdata(f3, wd));
          end
        end
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_store_word();
    test_load_byte();
    test_store_half();
    test_misalign();
    test_timeout();
    test_back_to_back();
    test_reset_mid_req();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
